multi_band_gs_sequencer: RTL

MULTI_BAND_GS_SEQUENCER -- requirements
Module: multi_band_gs_sequencer

---
 rtl/multi_band_gs_sequencer.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/multi_band_gs_sequencer.sv
// Grayscale bit-plane sequencer: fetches LED colour words per angle and shifts
// one bit per band out to the LED drivers, latching after every plane.
//
// state   | meaning
// IDLE    | waiting for an accepted angle_start
// FETCH   | r_en pulse for the current {buf, angle, row, color}
// WAIT    | read data valid, next SOUT bit captured
// SCLK_LO | SOUT settling, SCLK low for SCLK_DIV cycles
// SCLK_HI | SCLK high for SCLK_DIV cycles
// LATCH   | LAT high for SCLK_DIV cycles at the end of a plane
module multi_band_gs_sequencer #(
  parameter int NB_BANDS      = 4,
  parameter int NB_LED_COLUMN = 32,
  parameter int BIT_PER_COLOR = 8,
  parameter int NB_0_LSB      = 1,
  parameter int NB_ANGLES     = 128,
  parameter int PCB_ANGLE     = 0,
  parameter int SCLK_DIV      = 2,
  localparam int AW     = $clog2(NB_ANGLES),
  localparam int RW     = $clog2(NB_LED_COLUMN),
  localparam int PW     = $clog2(BIT_PER_COLOR + NB_0_LSB),
  localparam int ADDR_W = 1 + AW + RW + 2
) (
  input  logic                              clk,
  input  logic                              nrst,
  input  logic                              en,
  input  logic                              angle_start,
  input  logic [AW-1:0]                     angle,
  input  logic                              new_frame,
  output logic                              r_en,
  output logic [ADDR_W-1:0]                 r_addr,
  input  logic [NB_BANDS*BIT_PER_COLOR-1:0] r_data,
  input  logic                              hps_override,
  input  logic [NB_BANDS-1:0]               hps_SOUT,
  output logic                              SCLK,
  output logic                              LAT,
  output logic [NB_BANDS-1:0]               SOUT,
  output logic                              busy,
  output logic                              overrun,
  input  logic                              overrun_clr
);

  localparam int NP = BIT_PER_COLOR + NB_0_LSB;
  localparam int DW = NB_BANDS * BIT_PER_COLOR;
  localparam int IW = (DW > 1) ? $clog2(DW) : 1;
  localparam int CW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_LOAD  = CW'(SCLK_DIV - 1);
  localparam logic [PW-1:0] PLANE_TOP = PW'(NP - 1);
  localparam logic [RW-1:0] ROW_TOP   = RW'(NB_LED_COLUMN - 1);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, SCLK_LO, SCLK_HI, LATCH} state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       plane_q, plane_d;
  logic [RW-1:0]       row_q, row_d;
  logic [1:0]          color_q, color_d;
  logic [CW-1:0]       div_q, div_d;
  logic [AW-1:0]       angle_q, angle_d;
  logic                rd_buf_q, rd_buf_d;
  logic                pending_q, pending_d;
  logic                overrun_q, overrun_d;
  logic                busy_q, busy_d;
  logic                r_en_q, r_en_d;
  logic                sclk_q, sclk_d;
  logic                lat_q, lat_d;
  logic [NB_BANDS-1:0] sout_q, sout_d;
  logic [IW-1:0]       bit_idx;

  always_comb begin
    state_d = state_q;
    plane_d = plane_q;
    row_d   = row_q;
    color_d = color_q;
    div_d   = div_q;
    angle_d = angle_q;
    sout_d  = sout_q;
    bit_idx = '0;
    case (state_q)
      IDLE: begin
        if (angle_start && en) begin
          state_d = FETCH;
          angle_d = AW'((int'(angle) + PCB_ANGLE) % NB_ANGLES);
          plane_d = PLANE_TOP;
          row_d   = ROW_TOP;
          color_d = 2'd2;
        end
      end
      FETCH: state_d = WAIT;
      WAIT: begin
        state_d = SCLK_LO;
        div_d   = DIV_LOAD;
        // Planes below NB_0_LSB are padding and always shift out zero.
        for (int k = 0; k < NB_BANDS; k++) begin
          if (int'(plane_q) >= NB_0_LSB) begin
            bit_idx   = IW'(k * BIT_PER_COLOR + int'(plane_q) - NB_0_LSB);
            sout_d[k] = r_data[bit_idx];
          end else begin
            sout_d[k] = 1'b0;
          end
        end
      end
      SCLK_LO: begin
        if (div_q == '0) begin
          state_d = SCLK_HI;
          div_d   = DIV_LOAD;
        end else begin
          div_d = div_q - 1'b1;
        end
      end
      SCLK_HI: begin
        if (div_q != '0) begin
          div_d = div_q - 1'b1;
        end else if (row_q == '0 && color_q == 2'd0) begin
          state_d = LATCH;
          div_d   = DIV_LOAD;
        end else begin
          state_d = FETCH;
          if (color_q == 2'd0) begin
            color_d = 2'd2;
            row_d   = row_q - 1'b1;
          end else begin
            color_d = color_q - 1'b1;
          end
        end
      end
      LATCH: begin
        if (div_q != '0) begin
          div_d = div_q - 1'b1;
        end else if (plane_q == '0) begin
          state_d = IDLE;
        end else begin
          state_d = FETCH;
          plane_d = plane_q - 1'b1;
          row_d   = ROW_TOP;
          color_d = 2'd2;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_d    = (state_d != IDLE);
    r_en_d    = (state_d == FETCH);
    sclk_d    = (state_d == SCLK_HI);
    lat_d     = (state_d == LATCH);
    // A set in the same cycle as a clear wins so no overrun is ever lost.
    overrun_d = (angle_start && busy_q) || (overrun_q && !overrun_clr);
    rd_buf_d  = rd_buf_q;
    pending_d = pending_q;
    if (state_q == IDLE) begin
      if (new_frame) rd_buf_d = ~rd_buf_q;
    end else if (state_d == IDLE) begin
      rd_buf_d  = rd_buf_q ^ (pending_q | new_frame);
      pending_d = 1'b0;
    end else if (new_frame) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      plane_q   <= '0;
      row_q     <= '0;
      color_q   <= '0;
      div_q     <= '0;
      angle_q   <= '0;
      rd_buf_q  <= 1'b0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      busy_q    <= 1'b0;
      r_en_q    <= 1'b0;
      sclk_q    <= 1'b0;
      lat_q     <= 1'b0;
      sout_q    <= '0;
    end else begin
      state_q   <= state_d;
      plane_q   <= plane_d;
      row_q     <= row_d;
      color_q   <= color_d;
      div_q     <= div_d;
      angle_q   <= angle_d;
      rd_buf_q  <= rd_buf_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      busy_q    <= busy_d;
      r_en_q    <= r_en_d;
      sclk_q    <= sclk_d;
      lat_q     <= lat_d;
      sout_q    <= sout_d;
    end
  end

  assign r_en    = r_en_q;
  assign r_addr  = {rd_buf_q, angle_q, row_q, color_q};
  assign SCLK    = sclk_q;
  assign LAT     = lat_q;
  assign busy    = busy_q;
  assign overrun = overrun_q;
  assign SOUT    = hps_override ? hps_SOUT : sout_q;

endmodule
